bus_dma: RTL and testbench
==========================

BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 SHALL have parameter AW, default 16, meaning memory bus address width.
REQ-002 SHALL have parameter DW, default 16, meaning memory bus data width.
REQ-003 SHALL have port clki  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cfg_sel  input  2  config register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS.
REQ-006 SHALL have port cfg_wdata  input  DW  config write data.
REQ-007 SHALL have port cfg_write  input  1  config write strobe, one cycle per write.
REQ-008 SHALL have port cfg_rdata  output  DW  combinational readback of the selected register.
REQ-009 SHALL have port m_addr  output  AW  master bus address.
REQ-010 SHALL have port m_wdata  output  DW  master bus write data.
REQ-011 SHALL have port m_rdata  input  DW  master bus read data.
REQ-012 SHALL have ports m_read and m_write  output  1 each  master bus request strobes.
REQ-013 SHALL have ports m_busy and m_ready  input  1 each  responder wait and completion flags.
REQ-014 SHALL have port done_irq  output  1  one-cycle pulse at transfer end.

Function
REQ-015 SHALL treat a beat as complete on a rising edge where the request is asserted, m_busy=0 and m_ready=1.
REQ-016 SHALL hold m_addr, m_wdata and the active strobe stable from assertion until beat completion.
REQ-017 SHALL never assert m_read and m_write in the same cycle.
REQ-018 SHALL capture m_rdata into a holding register on read-beat completion.
REQ-019 SHALL implement FSM states IDLE, RD, WR, FIN.
REQ-020 SHALL transition IDLE->RD on CTRL write with bit0=1 when LEN!=0, and IDLE->FIN when LEN=0.
REQ-021 SHALL transition RD->WR on read completion, and WR->RD on write completion if remaining count>0.
REQ-022 SHALL transition WR->FIN on write completion when remaining count reaches 0.
REQ-023 SHALL pulse done_irq for one cycle in FIN, set the sticky done flag, and return to IDLE the next cycle.
REQ-024 SHALL, with a zero-wait responder, copy one word per 2 cycles with the first request asserted the cycle after the start write.
REQ-025 SHALL increment working source and destination addresses by 1 per completed beat, modulo 2^AW (0xFFFF wraps to 0x0000).
REQ-026 SHALL decrement the remaining count after each write completion; LEN is unsigned, with 0xFFFF meaning 65535 words.
REQ-027 SHALL ignore writes to SRC, DST and LEN, and any start request, while not IDLE.
REQ-028 SHALL, on CTRL write with bit1=1 while active, finish the in-flight beat, then go to FIN without setting done, and set the aborted flag instead.
REQ-029 SHALL read CTRL/STATUS as {13'b0, aborted, done, active}.
REQ-030 SHALL clear done and aborted on any accepted start.
REQ-031 SHALL give the abort bit priority over the start bit when both are written together.
REQ-032 SHALL read SRC, DST and LEN back as their programmed values, not the working copies.

Reset
REQ-033 SHALL, while rst_in=0, asynchronously force state IDLE, all registers and flags 0, and m_read=m_write=0, m_addr=0, m_wdata=0, done_irq=0.
REQ-034 SHALL, on rst_in low mid-beat, abandon the beat immediately with no completion or irq.
REQ-035 SHALL resume operation on the first rising edge of clki after rst_in returns high.

Verification
REQ-036 SHALL be verified by: SRC=0x5000, DST=0x6000, LEN=3, zero-wait responder -> reads of 5000/5001/5002 and writes of 6000/6001/6002 in 6 cycles, done_irq 1 cycle later, STATUS=0x0002.
REQ-037 SHALL be verified by: LEN=0 plus start -> no strobes ever asserted, done_irq on the cycle after start, STATUS=0x0002.
REQ-038 SHALL be verified by: m_busy=1 for 4 cycles on the first read -> m_read and m_addr stable for 5 cycles, data copied correctly.
REQ-039 SHALL be verified by: SRC=0xFFFF, DST=0x7FFF, LEN=2 -> reads 0xFFFF then 0x0000, writes 0x7FFF then 0x8000.
REQ-040 SHALL be verified by: abort written during the 2nd read of LEN=5 -> that read completes, no further strobes, STATUS=0x0004, done_irq pulses.
REQ-041 SHALL be verified by: rst_in low during a WR beat -> m_write=0 within the same cycle, STATUS=0x0000, SRC readback 0x0000.

Source files
------------

// File: rtl/bus_dma.sv
// rtl/bus_dma.sv - single-channel memory-to-memory copy engine with register config
module bus_dma #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clki,
    input  logic          rst_in,
    input  logic [1:0]    cfg_sel,
    input  logic [DW-1:0] cfg_wdata,
    input  logic          cfg_write,
    output logic [DW-1:0] cfg_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          m_read,
    output logic          m_write,
    input  logic          m_busy,
    input  logic          m_ready,
    output logic          done_irq
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t        state;
    logic [AW-1:0] src_r, dst_r, src_w, dst_w;
    logic [DW-1:0] len_r, cnt;
    logic          done_f, abort_f, abort_pend;

    logic ctrl_wr, abort_req, start_req, beat_done, stop, active;

    assign ctrl_wr   = cfg_write && (cfg_sel == 2'd3);
    assign abort_req = ctrl_wr && cfg_wdata[1];
    assign start_req = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
    assign beat_done = !m_busy && m_ready;
    // An abort arriving on the completing edge itself counts as pending.
    assign stop      = abort_pend || abort_req;
    assign active    = (state != IDLE);

    always_comb begin
        cfg_rdata = '0;
        case (cfg_sel)
            2'd0:    cfg_rdata = DW'(src_r);
            2'd1:    cfg_rdata = DW'(dst_r);
            2'd2:    cfg_rdata = len_r;
            default: cfg_rdata = DW'({abort_f, done_f, active});
        endcase
    end

    always_ff @(posedge clki or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            src_r      <= '0;
            dst_r      <= '0;
            len_r      <= '0;
            src_w      <= '0;
            dst_w      <= '0;
            cnt        <= '0;
            done_f     <= 1'b0;
            abort_f    <= 1'b0;
            abort_pend <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            done_irq   <= 1'b0;
        end else begin
            done_irq <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_write) begin
                        case (cfg_sel)
                            2'd0:    src_r <= AW'(cfg_wdata);
                            2'd1:    dst_r <= AW'(cfg_wdata);
                            2'd2:    len_r <= cfg_wdata;
                            default: ;
                        endcase
                    end
                    if (start_req) begin
                        done_f     <= 1'b0;
                        abort_f    <= 1'b0;
                        abort_pend <= 1'b0;
                        src_w      <= src_r;
                        dst_w      <= dst_r;
                        cnt        <= len_r;
                        if (len_r == '0) begin
                            state    <= FIN;
                            done_irq <= 1'b1;
                            done_f   <= 1'b1;
                        end else begin
                            state  <= RD;
                            m_read <= 1'b1;
                            m_addr <= src_r;
                        end
                    end
                end
                RD: begin
                    if (abort_req)
                        abort_pend <= 1'b1;
                    if (beat_done) begin
                        m_read  <= 1'b0;
                        m_wdata <= m_rdata;
                        src_w   <= src_w + AW'(1);
                        if (stop) begin
                            state    <= FIN;
                            done_irq <= 1'b1;
                            abort_f  <= 1'b1;
                        end else begin
                            state   <= WR;
                            m_write <= 1'b1;
                            m_addr  <= dst_w;
                        end
                    end
                end
                WR: begin
                    if (abort_req)
                        abort_pend <= 1'b1;
                    if (beat_done) begin
                        m_write <= 1'b0;
                        dst_w   <= dst_w + AW'(1);
                        cnt     <= cnt - DW'(1);
                        if (stop) begin
                            state    <= FIN;
                            done_irq <= 1'b1;
                            abort_f  <= 1'b1;
                        end else if (cnt == DW'(1)) begin
                            state    <= FIN;
                            done_irq <= 1'b1;
                            done_f   <= 1'b1;
                        end else begin
                            state  <= RD;
                            m_read <= 1'b1;
                            m_addr <= src_w;
                        end
                    end
                end
                FIN: begin
                    state      <= IDLE;
                    abort_pend <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma.sv
// tb/tb_bus_dma.sv - scoreboard bench for bus_dma with a stallable memory responder
module tb_bus_dma;

    logic        clki = 1'b0;
    logic        rst_in;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_wdata;
    logic        cfg_write;
    logic [15:0] cfg_rdata;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_read, m_write;
    logic        m_busy = 1'b0;
    logic        m_ready;
    logic        done_irq;

    bus_dma #(.AW(16), .DW(16)) dut (
        .clki(clki), .rst_in(rst_in), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .cfg_write(cfg_write), .cfg_rdata(cfg_rdata), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_read(m_read), .m_write(m_write),
        .m_busy(m_busy), .m_ready(m_ready), .done_irq(done_irq)
    );

    always #5 clki = ~clki;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  stall_cfg = 0;
    int  wait_left = 0;
    int  n;

    always @(posedge clki) cyc <= cyc + 1;

    assign m_rdata = m_read ? (m_addr ^ 16'hA5A5) : 16'h0000;
    assign m_ready = !m_busy;

    // Stall counter reloads whenever the bus is idle, so it applies to the first beat of a transfer.
    always @(posedge clki) begin
        #1;
        if ((m_read || m_write) && wait_left > 0) begin
            m_busy    = 1'b1;
            wait_left = wait_left - 1;
        end else begin
            m_busy = 1'b0;
            if (!(m_read || m_write))
                wait_left = stall_cfg;
        end
    end

    task automatic push(input int k, input logic [15:0] a, input logic [15:0] d, input int c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic expect_ev(input int k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d addr=%h data=%h cyc=%0d, required none", k, a, d, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k || (k != 2 && e.addr !== a) || (k == 1 && e.data !== d) || e.cyc != cyc) begin
                errors++;
                $display("FAIL event kind=%0d addr=%h data=%h cyc=%0d, required kind=%0d addr=%h data=%h cyc=%0d",
                         k, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
            end
        end
    endtask

    logic        have_prev = 1'b0;
    logic [33:0] prev;

    always @(negedge clki) begin
        if (!rst_in) begin
            have_prev = 1'b0;
        end else begin
            if (m_read || m_write) begin
                checks++;
                if (m_read && m_write) begin
                    errors++;
                    $display("FAIL strobe_excl read=%b write=%b, required not both", m_read, m_write);
                end
            end
            if (have_prev) begin
                checks++;
                if ({m_read, m_write, m_addr, m_wdata} !== prev) begin
                    errors++;
                    $display("FAIL stable got=%h, required %h", {m_read, m_write, m_addr, m_wdata}, prev);
                end
            end
            have_prev = 1'b0;
            if (m_read || m_write) begin
                if (!m_busy && m_ready)
                    expect_ev(m_write ? 1 : 0, m_addr, m_wdata);
                else begin
                    have_prev = 1'b1;
                    prev = {m_read, m_write, m_addr, m_wdata};
                end
            end
            if (done_irq)
                expect_ev(2, 16'h0, 16'h0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h, required %h", name, act, exp);
        end
    endtask

    task automatic cfg_wr(input logic [1:0] s, input logic [15:0] d);
        cfg_sel = s; cfg_wdata = d; cfg_write = 1'b1;
        @(posedge clki); #1;
        cfg_write = 1'b0;
    endtask

    task automatic read_reg(input string name, input logic [1:0] s, input logic [15:0] exp);
        cfg_sel = s;
        #1;
        check(name, {16'h0, cfg_rdata}, {16'h0, exp});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) begin
            @(posedge clki); #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d, required 0", name, q.size());
            q.delete();
        end
        repeat (2) begin
            @(posedge clki); #1;
        end
    endtask

    initial begin
        rst_in = 1'b0; cfg_sel = 2'd0; cfg_wdata = 16'h0; cfg_write = 1'b0;
        repeat (2) @(posedge clki);
        #1;
        check("rst_m_read", {31'h0, m_read}, 32'h0);
        check("rst_m_write", {31'h0, m_write}, 32'h0);
        check("rst_m_addr", {16'h0, m_addr}, 32'h0);
        check("rst_irq", {31'h0, done_irq}, 32'h0);
        read_reg("rst_status", 2'd3, 16'h0000);
        rst_in = 1'b1;
        @(posedge clki); #1;

        // Basic three-word copy, with config writes attempted mid-transfer.
        cfg_wr(2'd0, 16'h5000); cfg_wr(2'd1, 16'h6000); cfg_wr(2'd2, 16'h0003);
        n = cyc;
        push(0, 16'h5000, 16'h0, n + 1); push(1, 16'h6000, 16'h5000 ^ 16'hA5A5, n + 2);
        push(0, 16'h5001, 16'h0, n + 3); push(1, 16'h6001, 16'h5001 ^ 16'hA5A5, n + 4);
        push(0, 16'h5002, 16'h0, n + 5); push(1, 16'h6002, 16'h5002 ^ 16'hA5A5, n + 6);
        push(2, 16'h0, 16'h0, n + 7);
        cfg_wr(2'd3, 16'h0001);
        cfg_wr(2'd0, 16'h1234);
        cfg_wr(2'd3, 16'h0001);
        drain("copy3");
        read_reg("copy3_status", 2'd3, 16'h0002);
        read_reg("copy3_src", 2'd0, 16'h5000);
        read_reg("copy3_len", 2'd2, 16'h0003);

        // Zero length: immediate completion, no bus traffic.
        cfg_wr(2'd2, 16'h0000);
        n = cyc;
        push(2, 16'h0, 16'h0, n + 1);
        cfg_wr(2'd3, 16'h0001);
        drain("len0");
        read_reg("len0_status", 2'd3, 16'h0002);

        // First read stalled for four cycles.
        stall_cfg = 4;
        @(posedge clki); #1;
        cfg_wr(2'd0, 16'h0100); cfg_wr(2'd1, 16'h0200); cfg_wr(2'd2, 16'h0002);
        n = cyc;
        push(0, 16'h0100, 16'h0, n + 5); push(1, 16'h0200, 16'h0100 ^ 16'hA5A5, n + 6);
        push(0, 16'h0101, 16'h0, n + 7); push(1, 16'h0201, 16'h0101 ^ 16'hA5A5, n + 8);
        push(2, 16'h0, 16'h0, n + 9);
        cfg_wr(2'd3, 16'h0001);
        drain("stall");
        stall_cfg = 0;
        read_reg("stall_status", 2'd3, 16'h0002);

        // Address wrap on both source and destination.
        cfg_wr(2'd0, 16'hFFFF); cfg_wr(2'd1, 16'h7FFF); cfg_wr(2'd2, 16'h0002);
        n = cyc;
        push(0, 16'hFFFF, 16'h0, n + 1); push(1, 16'h7FFF, 16'h5A5A, n + 2);
        push(0, 16'h0000, 16'h0, n + 3); push(1, 16'h8000, 16'hA5A5, n + 4);
        push(2, 16'h0, 16'h0, n + 5);
        cfg_wr(2'd3, 16'h0001);
        drain("wrap");
        read_reg("wrap_status", 2'd3, 16'h0002);

        // Abort during the second read of a five-word copy.
        cfg_wr(2'd0, 16'h3000); cfg_wr(2'd1, 16'h4000); cfg_wr(2'd2, 16'h0005);
        n = cyc;
        push(0, 16'h3000, 16'h0, n + 1); push(1, 16'h4000, 16'h3000 ^ 16'hA5A5, n + 2);
        push(0, 16'h3001, 16'h0, n + 3); push(2, 16'h0, 16'h0, n + 4);
        cfg_wr(2'd3, 16'h0001);
        repeat (2) begin
            @(posedge clki); #1;
        end
        cfg_wr(2'd3, 16'h0002);
        drain("abort");
        read_reg("abort_status", 2'd3, 16'h0004);

        // Abort and start together while idle: no start, flags untouched.
        cfg_wr(2'd3, 16'h0003);
        drain("abort_start");
        read_reg("abort_start_status", 2'd3, 16'h0004);

        // Reset in the middle of a write beat.
        cfg_wr(2'd0, 16'h1111); cfg_wr(2'd1, 16'h2222); cfg_wr(2'd2, 16'h0003);
        n = cyc;
        push(0, 16'h1111, 16'h0, n + 1);
        cfg_wr(2'd3, 16'h0001);
        @(posedge clki); #1;
        check("mid_wr_strobe", {31'h0, m_write}, 32'h1);
        rst_in = 1'b0;
        #1;
        check("rst_wr_drop", {31'h0, m_write}, 32'h0);
        check("rst_rd_drop", {31'h0, m_read}, 32'h0);
        @(posedge clki); #1;
        read_reg("rst_mid_status", 2'd3, 16'h0000);
        read_reg("rst_mid_src", 2'd0, 16'h0000);
        rst_in = 1'b1;
        drain("after_rst");
        check("after_rst_irq", {31'h0, done_irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
